// File: rtl/compare_alarm_monitor.sv
// Debounced alarm monitor fed by a one-hot less/equal/greater comparator.
// Raises alarm after TRIP_CYCLES consecutive sampled "greater" results and
// drops it after CLEAR_CYCLES consecutive sampled "less" results. Also keeps
// a saturating trip counter and a sticky flag for non-one-hot comparator
// samples. Every output comes straight from a flop.
module compare_alarm_monitor #(
    parameter int TRIP_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 3,
    parameter int CNT_W        = 4,
    parameter int EVT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    input  logic             clr_stats,
    output logic             alarm,
    output logic             trip_pulse,
    output logic             clear_pulse,
    output logic [EVT_W-1:0] trip_cnt,
    output logic             onehot_err,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        ARMING    = 2'd1,
        ALARM_ST  = 2'd2,
        DISARMING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TRIP_L  = CNT_W'(TRIP_CYCLES);
    localparam logic [CNT_W-1:0] CLEAR_L = CNT_W'(CLEAR_CYCLES);
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    state_t           state, state_n;
    logic [CNT_W-1:0] run, run_n, run_inc;
    logic             onehot, is_g, is_l, is_x;
    logic             alarm_d, trip_d, clear_d, err_d;
    logic [EVT_W-1:0] cnt_d;

    // Classify the sampled comparator flags; X samples behave like E.
    always_comb begin
        onehot  = (less ^ equal ^ greater) & ~(less & equal & greater);
        is_g    = sample_en & greater & ~less & ~equal;
        is_l    = sample_en & less & ~equal & ~greater;
        is_x    = sample_en & ~onehot;
        run_inc = run + 1'b1;
    end

    // Next-state and run-length logic; nothing moves on unsampled cycles.
    always_comb begin
        state_n = state;
        run_n   = run;
        if (sample_en) begin
            case (state)
                NORMAL: begin
                    if (is_g) begin
                        run_n   = 1'b1;
                        state_n = (TRIP_CYCLES == 1) ? ALARM_ST : ARMING;
                    end else begin
                        run_n = '0;
                    end
                end
                ARMING: begin
                    if (is_g) begin
                        run_n = run_inc;
                        if (run_inc == TRIP_L) state_n = ALARM_ST;
                    end else begin
                        run_n   = '0;
                        state_n = NORMAL;
                    end
                end
                ALARM_ST: begin
                    if (is_l) begin
                        run_n   = 1'b1;
                        state_n = (CLEAR_CYCLES == 1) ? NORMAL : DISARMING;
                    end else begin
                        run_n = '0;
                    end
                end
                default: begin
                    if (is_l) begin
                        run_n = run_inc;
                        if (run_inc == CLEAR_L) state_n = NORMAL;
                    end else begin
                        run_n   = '0;
                        state_n = ALARM_ST;
                    end
                end
            endcase
        end
    end

    // Next values of the registered outputs, derived from the transition.
    always_comb begin
        alarm_d = (state_n == ALARM_ST) || (state_n == DISARMING);
        trip_d  = (state_n == ALARM_ST) && ((state == NORMAL) || (state == ARMING));
        clear_d = (state_n == NORMAL) && ((state == ALARM_ST) || (state == DISARMING));
        cnt_d   = trip_cnt;
        if (clr_stats) begin
            cnt_d = trip_d ? EVT_W'(1) : '0;
        end else if (trip_d && (trip_cnt != EVT_MAX)) begin
            cnt_d = trip_cnt + 1'b1;
        end
        // A fresh illegal sample wins over a simultaneous clear.
        err_d = is_x ? 1'b1 : (clr_stats ? 1'b0 : onehot_err);
    end

    // State register and output flops; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NORMAL;
            run         <= '0;
            alarm       <= 1'b0;
            trip_pulse  <= 1'b0;
            clear_pulse <= 1'b0;
            trip_cnt    <= '0;
            onehot_err  <= 1'b0;
        end else begin
            state       <= state_n;
            run         <= run_n;
            alarm       <= alarm_d;
            trip_pulse  <= trip_d;
            clear_pulse <= clear_d;
            trip_cnt    <= cnt_d;
            onehot_err  <= err_d;
        end
    end

    assign state_o = state;

endmodule

// File: doc/compare_alarm_monitor.md
Name: compare_alarm_monitor

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator; consumes its one-hot less/equal/greater flags.
- Debounces the flags into a hysteretic alarm. Alarm trips after TRIP_CYCLES consecutive sampled "greater" results and clears after CLEAR_CYCLES consecutive sampled "less" results.
- Also keeps a saturating trip counter and a sticky flag for illegal (non-one-hot) comparator outputs. Feeds the status/interrupt logic.

Parameters:
- TRIP_CYCLES, 4: consecutive sampled "greater" results required to raise alarm. Legal range 1..2^CNT_W-1.
- CLEAR_CYCLES, 3: consecutive sampled "less" results required to drop alarm. Legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the internal run-length counter.
- EVT_W, 8: width of trip_cnt.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_en  input  1  comparator flags are valid this cycle.
- less  input  1  comparator A<B flag.
- equal  input  1  comparator A==B flag.
- greater  input  1  comparator A>B flag.
- clr_stats  input  1  synchronous clear of trip_cnt and onehot_err.
- alarm  output  1  debounced alarm level.
- trip_pulse  output  1  one-cycle pulse on alarm assertion.
- clear_pulse  output  1  one-cycle pulse on alarm deassertion.
- trip_cnt  output  EVT_W  saturating count of alarm trips.
- onehot_err  output  1  sticky: illegal flag combination was sampled.
- state_o  output  2  FSM state, for debug.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge, including mid-operation): state=NORMAL, run counter=0, alarm=0, trip_pulse=0, clear_pulse=0, trip_cnt=0, onehot_err=0. Reset overrides every other input.
- All outputs are registered. State encoding on state_o: NORMAL=0, ARMING=1, ALARM=2, DISARMING=3.
- Sample classification applies only when sample_en=1:
  - G: exactly greater=1.
  - L: exactly less=1.
  - E: exactly equal=1.
  - X: any other combination, including all-zero. onehot_err is set and the sample is treated as E.
- sample_en=0: state, run counter, alarm and trip_cnt hold; trip_pulse and clear_pulse are 0; flag inputs are ignored, so onehot_err is not set.
- Transitions, evaluated on a sampled cycle:
  - NORMAL: G -> run=1; go to ALARM if TRIP_CYCLES==1, else ARMING. L/E/X -> stay, run=0.
  - ARMING: G -> run+1; if run+1==TRIP_CYCLES go to ALARM, else stay. L/E/X -> NORMAL, run=0.
  - ALARM: L -> run=1; go to NORMAL if CLEAR_CYCLES==1, else DISARMING. G/E/X -> stay, run=0.
  - DISARMING: L -> run+1; if run+1==CLEAR_CYCLES go to NORMAL, else stay. G/E/X -> ALARM, run=0.
- alarm=1 exactly when the state is ALARM or DISARMING. It stays high through DISARMING.
- Latency: the edge that samples the TRIP_CYCLES-th consecutive G also sets alarm=1 and trip_pulse=1. trip_pulse falls at the next edge. clear_pulse behaves the same way on entry to NORMAL from ALARM or DISARMING.
- trip_cnt: increments by 1 on every trip and saturates at 2^EVT_W-1 (no wrap).
- clr_stats: zeroes trip_cnt and onehot_err.
  - If a trip occurs in the same cycle as clr_stats, trip_cnt=1.
  - If an X sample occurs in the same cycle as clr_stats, onehot_err=1 (set wins).
- clr_stats does not affect the state, run counter or alarm.
- The run counter never exceeds TRIP_CYCLES or CLEAR_CYCLES. No overflow is possible within the legal parameter range.

Test Plan:
- Reset, then 4 sampled G (defaults): alarm and trip_pulse rise at the 4th sampling edge; trip_cnt=1; state_o sequence 0,1,1,1,2.
- 3 G, 1 E, 4 G: no trip after the first 3 G (state returns to 0 on E); trip occurs only on the final 4th G; trip_cnt=1.
- In ALARM, apply L,L,G,L,L,L: state goes 3,3,2,3,3,0; clear_pulse fires only on the last L; alarm stays 1 until then.
- G,G,sample_en=0 for 5 cycles,G,G: trip occurs on the 4th sampled G; pulses stay low during the idle cycles.
- Flags 3'b101 sampled: onehot_err=1 and the run resets. Next cycle clr_stats together with a legal flag: onehot_err=0. clr_stats coincident with a trip: trip_cnt=1.
- EVT_W=2: 5 trip/clear cycles give trip_cnt=3 (saturated). rst asserted mid-ARMING: all outputs 0, state_o=0 the next cycle.
